threshold_compress: RTL and testbench
=====================================

THRESHOLD_COMPRESS -- requirements
Module: threshold_compress

Interface
REQ-001 SHALL have parameter OUTPUT_WIDTH, default 8, width of one compressed output word; 8 is the only supported value.
REQ-002 SHALL derive localparams COMPREG_WIDTH = OUTPUT_WIDTH*5/4 (10) and N_TRITS = COMPREG_WIDTH/2 (5).
REQ-003 SHALL use one clock, clk_i; reset rst_i is synchronous and active-high.
REQ-004 clk_i  in  1  rising-edge clock.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 data_i  in  32  signed two's-complement preactivation.
REQ-007 thresholds_i  in  32  [15:0] signed low threshold LO, [31:16] signed high threshold HI.
REQ-008 enable_i  in  1  when high, data_i is consumed at this rising edge.
REQ-009 data_o  out  OUTPUT_WIDTH  compressed word of N_TRITS trits.
REQ-010 ready_o  out  1  one-cycle pulse marking data_o as a newly completed word.

Function
REQ-011 SHALL sign-extend LO and HI to 32 bits and compare them signed against data_i.
REQ-012 SHALL ternarize: data_i < LO gives trit -1; data_i >= HI gives +1; otherwise 0. If LO > HI, the +1 test has priority.
REQ-013 SHALL map each trit to digit d = trit+1 (0,1,2) and store it as 2 bits in a COMPREG_WIDTH shift/compression register.
REQ-014 SHALL keep a trit counter 0..N_TRITS-1 that increments on every edge with enable_i high and wraps to 0 after N_TRITS-1.
REQ-015 SHALL ignore edges with enable_i low: no sample taken, counter held, register held.
REQ-016 SHALL encode the k-th sample of a group (k=0 first) with weight 3^k: data_o = sum d_k*3^k, range 0..242.
REQ-017 SHALL register data_o and raise ready_o on the same edge that samples the N_TRITS-th trit; both are visible immediately after that edge (latency 0 cycles after the last sample edge).
REQ-018 SHALL hold ready_o high for exactly one cycle.
REQ-019 SHALL hold data_o until the next completed word.
REQ-020 SHALL start the next group at the following enabled edge, so back-to-back groups sustain one word per N_TRITS enabled cycles.
REQ-021 SHALL sample thresholds_i together with each data_i; thresholds may change per sample.

Reset
REQ-022 On rst_i high at a rising edge: counter=0, compression register=0, data_o=0, ready_o=0.
REQ-023 Reset SHALL override enable_i.
REQ-024 A partial group interrupted by reset SHALL be discarded and SHALL NOT produce a ready_o pulse.

Structure
REQ-025 SHALL place trit encoding constants (TRIT_NEG=2'b00, TRIT_ZERO=2'b01, TRIT_POS=2'b10) and the N_TRITS/COMPREG_WIDTH relations in shared package tnn_pkg.
REQ-026 SHALL implement the base-3 to binary conversion (COMPREG_WIDTH bits in, OUTPUT_WIDTH bits out) as combinational sub-module trit_encoder.
REQ-027 Thresholding, counter and output registers SHALL remain in threshold_compress.

Verification (thresholds_i = 32'h000A_FFF6, i.e. LO=-10, HI=10)
REQ-028 Five enabled samples of 0 -> ready_o pulse with data_o=121; all +100 -> 242; all -100 -> 0.
REQ-029 Sequence +100, 0, -100, 0, 0 -> data_o=113 (2+3+0+27+81).
REQ-030 Boundaries: five samples of 10 -> 242; five samples of -10 -> 121; five samples of -11 -> 0.
REQ-031 Enable gaps: samples 0,0 (enable high), two cycles enable low with data_i=+100, then 0,0,0 -> single pulse, data_o=121, no pulse during gaps.
REQ-032 Reset mid-group: three +100 samples, rst_i for one edge, then five 0 samples -> no pulse before reset, one pulse with 121 after; data_o=0 and ready_o=0 right after reset.
REQ-033 Ten back-to-back enabled samples -> ready_o pulses on edges 5 and 10 only, data_o holds between pulses.

Source files
------------

// File: rtl/tnn_pkg.sv
// tnn_pkg: shared trit encodings and compression-register size relations
package tnn_pkg;
  localparam logic [1:0] TRIT_NEG  = 2'b00;
  localparam logic [1:0] TRIT_ZERO = 2'b01;
  localparam logic [1:0] TRIT_POS  = 2'b10;
  function automatic int compreg_width(input int output_width);
    return output_width * 5 / 4;
  endfunction
  function automatic int n_trits(input int compreg_w);
    return compreg_w / 2;
  endfunction
endpackage

// File: rtl/trit_encoder.sv
// trit_encoder: packs base-3 digits (2 bits each, digit k at bits [2k+1:2k]) into binary sum d_k*3^k
module trit_encoder import tnn_pkg::*; #(
  parameter int OUTPUT_WIDTH = 8,
  parameter int COMPREG_WIDTH = compreg_width(OUTPUT_WIDTH)
) (
  input  logic [COMPREG_WIDTH-1:0] digits_i,
  output logic [OUTPUT_WIDTH-1:0]  value_o
);
  localparam int N_TRITS = n_trits(COMPREG_WIDTH);
  // Horner evaluation from the most significant (last sampled) digit down
  always_comb begin
    value_o = '0;
    for (int k = N_TRITS - 1; k >= 0; k--)
      value_o = OUTPUT_WIDTH'(value_o * 3 + {{(OUTPUT_WIDTH-2){1'b0}}, digits_i[2*k +: 2]});
  end
endmodule

// File: rtl/threshold_compress.sv
// threshold_compress: ternarizes preactivations against per-sample thresholds and packs five trits per word
module threshold_compress import tnn_pkg::*; #(
  parameter int OUTPUT_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [31:0]             data_i,
  input  logic [31:0]             thresholds_i,
  input  logic                    enable_i,
  output logic [OUTPUT_WIDTH-1:0] data_o,
  output logic                    ready_o
);
  localparam int COMPREG_WIDTH = compreg_width(OUTPUT_WIDTH);
  localparam int N_TRITS = n_trits(COMPREG_WIDTH);
  localparam int CNT_W = $clog2(N_TRITS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TRITS - 1);
  logic signed [31:0]       w_data, w_lo, w_hi;
  logic [1:0]               w_digit;
  logic [COMPREG_WIDTH-1:0] w_next;
  logic [OUTPUT_WIDTH-1:0]  w_word;
  logic                     w_last;
  logic [COMPREG_WIDTH-1:0] r_comp;
  logic [CNT_W-1:0]         r_cnt;
  logic [OUTPUT_WIDTH-1:0]  r_data;
  logic                     r_ready;
  assign w_data = data_i;
  assign w_lo = {{16{thresholds_i[15]}}, thresholds_i[15:0]};
  assign w_hi = {{16{thresholds_i[31]}}, thresholds_i[31:16]};
  // +1 test first so it wins when LO > HI
  always_comb begin
    w_digit = (w_data >= w_hi) ? TRIT_POS : (w_data < w_lo) ? TRIT_NEG : TRIT_ZERO;
    w_last = r_cnt == LAST;
    w_next = {w_digit, r_comp[COMPREG_WIDTH-1:2]};
  end
  trit_encoder #(.OUTPUT_WIDTH(OUTPUT_WIDTH), .COMPREG_WIDTH(COMPREG_WIDTH)) u_enc (
    .digits_i (w_next),
    .value_o  (w_word)
  );
  // new digits enter at the top, so after a full group the first sample sits at the bottom (weight 3^0)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_comp <= '0;
      r_cnt <= '0;
      r_data <= '0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= enable_i && w_last;
      if (enable_i) begin
        r_comp <= w_next;
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        if (w_last) r_data <= w_word;
      end
    end
  end
  assign data_o = r_data;
  assign ready_o = r_ready;
endmodule

// File: tb/tb_threshold_compress.sv
// tb_threshold_compress: directed and randomized checks against a queue-based trit model
module tb_threshold_compress;
  logic        clk_i = 1'b0;
  logic        rst_i, enable_i;
  logic [31:0] data_i, thresholds_i;
  logic [7:0]  data_o;
  logic        ready_o;
  localparam logic [31:0] THR = 32'h000A_FFF6;
  int passed = 0, checks = 0;
  int q[$];
  int exp_data = 0;
  int exp_ready = 0;

  threshold_compress #(.OUTPUT_WIDTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .thresholds_i(thresholds_i),
    .enable_i(enable_i), .data_o(data_o), .ready_o(ready_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int digit(input logic [31:0] d, input logic [31:0] t);
    int v, lo, hi;
    v = $signed(d);
    lo = $signed(t[15:0]);
    hi = $signed(t[31:16]);
    if (v >= hi) return 2;
    if (v < lo) return 0;
    return 1;
  endfunction

  function automatic int word_of(input int dq[$]);
    int w = 0, p = 1;
    foreach (dq[i]) begin
      w += dq[i] * p;
      p *= 3;
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  task automatic cyc(input logic [31:0] d, input logic [31:0] t, input logic en, input logic rs);
    data_i = d;
    thresholds_i = t;
    enable_i = en;
    rst_i = rs;
    @(posedge clk_i);
    #1;
    exp_ready = 0;
    if (rs) begin
      q.delete();
      exp_data = 0;
    end else if (en) begin
      q.push_back(digit(d, t));
      if (q.size() == 5) begin
        exp_data = word_of(q);
        exp_ready = 1;
        q.delete();
      end
    end
    chk("ready", {31'd0, ready_o}, exp_ready);
    chk("data", {24'd0, data_o}, exp_data);
  endtask

  task automatic group5(input logic [31:0] d, input int expw);
    for (int i = 0; i < 5; i++) cyc(d, THR, 1'b1, 1'b0);
    chk("word_ready", {31'd0, ready_o}, 1);
    chk("word_value", {24'd0, data_o}, expw);
  endtask

  initial begin
    logic [31:0] d, t;
    logic [31:0] seq [5];
    cyc(32'd0, THR, 1'b1, 1'b1);
    cyc(32'd0, THR, 1'b1, 1'b1);
    chk("reset_data", {24'd0, data_o}, 0);
    chk("reset_ready", {31'd0, ready_o}, 0);
    group5(32'd0, 121);
    group5(32'd100, 242);
    group5(-32'sd100, 0);
    seq = '{32'd100, 32'd0, -32'sd100, 32'd0, 32'd0};
    for (int i = 0; i < 5; i++) cyc(seq[i], THR, 1'b1, 1'b0);
    chk("mixed_word", {24'd0, data_o}, 113);
    group5(32'd10, 242);
    group5(-32'sd10, 121);
    group5(-32'sd11, 0);
    cyc(32'd0, THR, 1'b1, 1'b0);
    cyc(32'd0, THR, 1'b1, 1'b0);
    cyc(32'd100, THR, 1'b0, 1'b0);
    cyc(32'd100, THR, 1'b0, 1'b0);
    cyc(32'd0, THR, 1'b1, 1'b0);
    cyc(32'd0, THR, 1'b1, 1'b0);
    cyc(32'd0, THR, 1'b1, 1'b0);
    chk("gap_word", {24'd0, data_o}, 121);
    chk("gap_ready", {31'd0, ready_o}, 1);
    for (int i = 0; i < 3; i++) cyc(32'd100, THR, 1'b1, 1'b0);
    cyc(32'd100, THR, 1'b1, 1'b1);
    chk("mid_reset_data", {24'd0, data_o}, 0);
    chk("mid_reset_ready", {31'd0, ready_o}, 0);
    group5(32'd0, 121);
    for (int i = 0; i < 10; i++) cyc((i < 5) ? 32'd100 : 32'd0, THR, 1'b1, 1'b0);
    chk("b2b_word", {24'd0, data_o}, 121);
    cyc(32'd0, THR, 1'b0, 1'b0);
    chk("b2b_hold", {24'd0, data_o}, 121);
    for (int i = 0; i < 600; i++) begin
      t = {16'(int'($urandom_range(0, 40)) - 20), 16'(int'($urandom_range(0, 40)) - 20)};
      d = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'(int'($urandom_range(0, 60)) - 30);
      cyc(d, t, $urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
